// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and constants for the iterative ALU: the 3-bit
//                operation codes, the branch opcodes that change how the zero
//                flag is evaluated, the controller states and the default
//                difference-shift overflow value.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SLT = 3'b011,
        ALU_DSH = 3'b100,
        ALU_MUL = 3'b101,
        ALU_DIV = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    localparam logic [5:0] OP_BGE = 6'b100110;
    localparam logic [5:0] OP_BLT = 6'b000001;
    localparam logic [5:0] OP_BNE = 6'b000101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    localparam logic [31:0] DEFAULT_SENTINEL = 32'hc0debabe;

endpackage
`default_nettype wire

// File: rtl/iter_alu_if.sv
`default_nettype none
// ============================================================================
//  Module      : iter_alu_if
//  Description : Request/response bundle between the execute-stage controller
//                (master) and the iterative ALU (slave).
//                Request : start, a, b, d, alucontrol, opcode, shamt
//                Response: busy, done, result, hi, zero
//  Revision    : 1.0 - initial release
// ============================================================================
interface iter_alu_if #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] d;
    logic [3:0]       alucontrol;
    logic [5:0]       opcode;
    logic [CW-1:0]    shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             zero;

    modport master (
        output start, a, b, d, alucontrol, opcode, shamt,
        input  busy, done, result, hi, zero
    );

    modport slave (
        input  start, a, b, d, alucontrol, opcode, shamt,
        output busy, done, result, hi, zero
    );
endinterface
`default_nettype wire

// File: rtl/iter_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : iter_muldiv
//  Description : One-bit-per-step unsigned shift-add multiplier and restoring
//                divider sharing one {hi,lo} register pair. The parent FSM
//                owns the iteration count and pulses i_load / i_step.
//                Ports: clk, rst (async, active-high), i_load, i_step,
//                i_mode (0 = multiply, 1 = divide), i_a, i_b,
//                o_lo_next / o_hi_next (register values after this step).
//  Revision    : 1.0 - initial release
// ============================================================================
module iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic             i_step,
    input  wire logic             i_mode,
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    output logic      [WIDTH-1:0] o_lo_next,
    output logic      [WIDTH-1:0] o_hi_next
);

    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_opb;
    logic             r_mode;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_trial;

    // Multiply: lo holds the unconsumed multiplier bits, hi the partial
    // product; each step adds b when the low bit is set and shifts right.
    // Divide: lo holds the dividend bits and collects quotient bits, hi is
    // the partial remainder. The trial subtraction borrows (bit WIDTH set)
    // exactly when the shifted remainder is below the divisor. With b == 0
    // the trial never borrows, giving an all-ones quotient and remainder a.
    always_comb begin
        o_lo_next = r_lo;
        o_hi_next = r_hi;
        w_add     = '0;
        w_shl     = '0;
        w_trial   = '0;
        if (!r_mode) begin
            w_add = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
            {o_hi_next, o_lo_next} = {w_add, r_lo[WIDTH-1:1]};
        end else begin
            w_shl   = {r_hi, r_lo[WIDTH-1]};
            w_trial = w_shl - {1'b0, r_opb};
            if (!w_trial[WIDTH]) begin
                o_hi_next = w_trial[WIDTH-1:0];
                o_lo_next = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                o_hi_next = w_shl[WIDTH-1:0];
                o_lo_next = {r_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo   <= '0;
            r_hi   <= '0;
            r_opb  <= '0;
            r_mode <= 1'b0;
        end else if (i_load) begin
            r_lo   <= i_a;
            r_hi   <= '0;
            r_opb  <= i_b;
            r_mode <= i_mode;
        end else if (i_step) begin
            r_lo   <= o_lo_next;
            r_hi   <= o_hi_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/iter_alu.sv
`default_nettype none
// ============================================================================
//  Module      : iter_alu
//  Description : Handshaked execute-stage ALU. Logic, add/sub, slt, srl and
//                difference-shift finish one cycle after acceptance; unsigned
//                multiply/divide iterate WIDTH cycles in iter_muldiv.
//                Ports: clk, reset (async, active-high),
//                bus (iter_alu_if.slave): start/a/b/d/alucontrol/opcode/shamt
//                in; busy/done/result/hi/zero out.
//  Revision    : 1.0 - initial release
// ============================================================================
module iter_alu
    import alu_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] SENTINEL = DEFAULT_SENTINEL,
    parameter int          CW       = $clog2(WIDTH + 1)
) (
    input  wire logic  clk,
    input  wire logic  reset,
    iter_alu_if.slave  bus
);

    localparam logic [WIDTH-1:0] c_width_val = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] c_sentinel  = WIDTH'(SENTINEL);
    localparam logic [CW-1:0]    c_last      = CW'(WIDTH - 1);

    alu_state_e       r_state;
    alu_state_e       w_state_next;
    logic [CW-1:0]    r_count;
    logic [5:0]       r_opcode;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic             r_zero;

    alu_op_e          w_op;
    logic             w_is_md;
    logic             w_div;
    logic             w_accept;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_bsel;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_single;
    logic [WIDTH-1:0] w_md_lo_next;
    logic [WIDTH-1:0] w_md_hi_next;

    function automatic logic zero_of(input logic [WIDTH-1:0] v, input logic [5:0] opc);
        case (opc)
            OP_BGE:  return ~v[WIDTH-1];
            OP_BLT:  return v[WIDTH-1];
            OP_BNE:  return |v;
            default: return ~|v;
        endcase
    endfunction

    assign w_op    = alu_op_e'(bus.alucontrol[2:0]);
    assign w_is_md = (w_op == ALU_MUL) || (w_op == ALU_DIV);
    assign w_div   = (w_op == ALU_DIV);

    // Single-cycle datapath, evaluated on the live inputs so the accepting
    // edge captures the finished value directly.
    always_comb begin
        w_bsel   = bus.alucontrol[3] ? ~bus.b : bus.b;
        w_sum    = bus.a + w_bsel + {{(WIDTH-1){1'b0}}, bus.alucontrol[3]};
        w_diff   = bus.a + ~bus.b + {{(WIDTH-1){1'b0}}, bus.alucontrol[3]};
        w_single = '0;
        case (w_op)
            ALU_AND: w_single = bus.a & bus.b;
            ALU_OR:  w_single = bus.a | bus.b;
            ALU_ADD: w_single = w_sum;
            ALU_SLT: w_single = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1]};
            // A shift of exactly WIDTH already yields zero; only larger
            // differences are flagged with the sentinel.
            ALU_DSH: w_single = (w_diff > c_width_val) ? c_sentinel : (bus.d << w_diff);
            ALU_SRL: w_single = bus.b >> bus.shamt;
            default: w_single = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    if (w_is_md) begin
                        w_load       = 1'b1;
                        w_state_next = RUN;
                    end else begin
                        w_state_next = DONE;
                    end
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_count == c_last) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs update only on a single-cycle accept or on the final
    // iteration, so they hold through IDLE until the next accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_opcode <= '0;
            r_result <= '0;
            r_hi     <= '0;
            r_zero   <= 1'b0;
        end else begin
            if (w_load) begin
                r_count <= '0;
            end else if (w_step) begin
                r_count <= r_count + CW'(1);
            end
            if (w_accept) begin
                r_opcode <= bus.opcode;
            end
            if (w_accept && !w_is_md) begin
                r_result <= w_single;
                r_hi     <= '0;
                r_zero   <= zero_of(w_single, bus.opcode);
            end else if (w_last) begin
                r_result <= w_md_lo_next;
                r_hi     <= w_md_hi_next;
                r_zero   <= zero_of(w_md_lo_next, r_opcode);
            end
        end
    end

    iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .rst       (reset),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_mode    (w_div),
        .i_a       (bus.a),
        .i_b       (bus.b),
        .o_lo_next (w_md_lo_next),
        .o_hi_next (w_md_hi_next)
    );

    assign bus.busy   = (r_state == RUN);
    assign bus.done   = (r_state == DONE);
    assign bus.result = r_result;
    assign bus.hi     = r_hi;
    assign bus.zero   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_iter_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iter_alu
//  Description : Self-checking bench for iter_alu at WIDTH=32 and WIDTH=8.
//                Table-driven vectors plus hand-written back-to-back,
//                asynchronous-reset and narrow-width sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_alu;

    typedef struct {
        logic [31:0] a, b, d;
        logic [3:0]  ctl;
        logic [5:0]  opc;
        logic [5:0]  sh;
        logic [31:0] res, hi;
        logic        z;
        int          lat;
        bit          poke;
    } vec_t;

    typedef struct {
        logic [31:0] res, hi;
        logic        z;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic reset8;
    always #5 clk = ~clk;

    iter_alu_if #(.WIDTH(32)) bus32 ();
    iter_alu_if #(.WIDTH(8))  bus8 ();

    iter_alu #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset),  .bus(bus32.slave));
    iter_alu #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset8), .bus(bus8.slave));

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, b, d, input logic [3:0] ctl,
                                input logic [5:0] opc, sh, input logic [31:0] res, hi,
                                input logic z, input int lat, input bit poke);
        vec_t v;
        v.a = a; v.b = b; v.d = d; v.ctl = ctl; v.opc = opc; v.sh = sh;
        v.res = res; v.hi = hi; v.z = z; v.lat = lat; v.poke = poke;
        return v;
    endfunction

    task automatic do_op(input int idx);
        vec_t v;
        exp_t e;
        int   cyc;
        int   busy_n;
        int   extra;
        bit   got;
        v = vecs[idx];
        cyc = 0; busy_n = 0; got = 0;
        @(negedge clk);
        bus32.a = v.a; bus32.b = v.b; bus32.d = v.d;
        bus32.alucontrol = v.ctl; bus32.opcode = v.opc; bus32.shamt = v.sh;
        bus32.start = 1'b1;
        e.res = v.res; e.hi = v.hi; e.z = v.z; e.lat = v.lat;
        sb.push_back(e);
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            // Scramble inputs after acceptance: they must not matter.
            bus32.a = $urandom(); bus32.b = $urandom(); bus32.d = $urandom();
            bus32.alucontrol = 4'($urandom()); bus32.opcode = 6'($urandom());
            bus32.shamt = 6'($urandom());
            bus32.start = v.poke && cyc >= 5 && cyc <= 8;
            if (bus32.busy) busy_n++;
            if (bus32.done) got = 1;
        end
        bus32.start = 1'b0;
        chk($sformatf("vec%0d done_seen", idx), 32'(got), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (got) begin
                chk($sformatf("vec%0d result", idx), bus32.result, e.res);
                chk($sformatf("vec%0d hi", idx), bus32.hi, e.hi);
                chk($sformatf("vec%0d zero", idx), 32'(bus32.zero), 32'(e.z));
                chk($sformatf("vec%0d latency", idx), 32'(cyc), 32'(e.lat));
                chk($sformatf("vec%0d busy_cycles", idx), 32'(busy_n), 32'(e.lat - 1));
            end
        end
        if (v.poke) begin
            extra = 0;
            repeat (40) begin
                @(negedge clk);
                if (bus32.done) extra++;
            end
            chk($sformatf("vec%0d no_second_done", idx), 32'(extra), 32'd0);
        end
    endtask

    task automatic op8(input string name, input logic [7:0] a, b, input logic [3:0] ctl,
                       input logic [7:0] res, hi, input int lat);
        exp_t e;
        int   cyc;
        bit   got;
        cyc = 0; got = 0;
        @(negedge clk);
        bus8.a = a; bus8.b = b; bus8.d = 8'd1; bus8.alucontrol = ctl;
        bus8.opcode = 6'd0; bus8.shamt = 4'd0; bus8.start = 1'b1;
        e.res = {24'd0, res}; e.hi = {24'd0, hi}; e.z = (res == 8'd0); e.lat = lat;
        sb.push_back(e);
        while (!got && cyc < 30) begin
            @(negedge clk);
            cyc++;
            bus8.start = 1'b0;
            if (bus8.done) got = 1;
        end
        chk({name, " done_seen"}, 32'(got), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (got) begin
                chk({name, " result"}, {24'd0, bus8.result}, e.res);
                chk({name, " hi"}, {24'd0, bus8.hi}, e.hi);
                chk({name, " zero"}, 32'(bus8.zero), 32'(e.z));
                chk({name, " latency"}, 32'(cyc), 32'(e.lat));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        int  extra;
        bit  got;

        //            a             b             d      ctl      opc        sh     res           hi           z  lat poke
        vecs[0]  = mk(32'd5,        32'd3,        32'd0, 4'b0010, 6'b000000, 6'd0,  32'd8,        32'd0,       0, 1,  0);
        vecs[1]  = mk(32'd7,        32'd7,        32'd0, 4'b1010, 6'b000100, 6'd0,  32'd0,        32'd0,       1, 1,  0);
        vecs[2]  = mk(32'd7,        32'd7,        32'd0, 4'b1010, 6'b000101, 6'd0,  32'd0,        32'd0,       0, 1,  0);
        vecs[3]  = mk(32'd2,        32'd7,        32'd0, 4'b1010, 6'b000001, 6'd0,  32'hFFFFFFFB, 32'd0,       1, 1,  0);
        vecs[4]  = mk(32'hF0F01234, 32'h0FF0FF00, 32'd0, 4'b0000, 6'b100110, 6'd0,  32'h00F01200, 32'd0,       1, 1,  0);
        vecs[5]  = mk(32'h80000001, 32'h00000100, 32'd0, 4'b0001, 6'b100110, 6'd0,  32'h80000101, 32'd0,       0, 1,  0);
        vecs[6]  = mk(32'd2,        32'd7,        32'd0, 4'b1011, 6'b000000, 6'd0,  32'd1,        32'd0,       0, 1,  0);
        vecs[7]  = mk(32'd7,        32'd2,        32'd0, 4'b1011, 6'b000000, 6'd0,  32'd0,        32'd0,       1, 1,  0);
        vecs[8]  = mk(32'd5,        32'd3,        32'd1, 4'b1100, 6'b000000, 6'd0,  32'd4,        32'd0,       0, 1,  0);
        vecs[9]  = mk(32'd40,       32'd3,        32'd1, 4'b1100, 6'b000000, 6'd0,  32'hC0DEBABE, 32'd0,       0, 1,  0);
        vecs[10] = mk(32'd35,       32'd3,        32'd1, 4'b1100, 6'b000000, 6'd0,  32'd0,        32'd0,       1, 1,  0);
        vecs[11] = mk(32'd5,        32'd3,        32'd3, 4'b0100, 6'b000000, 6'd0,  32'd6,        32'd0,       0, 1,  0);
        vecs[12] = mk(32'd0,        32'h80000000, 32'd0, 4'b0111, 6'b000000, 6'd31, 32'd1,        32'd0,       0, 1,  0);
        vecs[13] = mk(32'd0,        32'h80000000, 32'd0, 4'b0111, 6'b000000, 6'd32, 32'd0,        32'd0,       1, 1,  0);
        vecs[14] = mk(32'hFFFFFFFF, 32'd2,        32'd0, 4'b0101, 6'b000000, 6'd0,  32'hFFFFFFFE, 32'd1,       0, 33, 1);
        vecs[15] = mk(32'h00010000, 32'h00010000, 32'd0, 4'b0101, 6'b000000, 6'd0,  32'd0,        32'd1,       1, 33, 0);
        vecs[16] = mk(32'd1000,     32'd1000,     32'd0, 4'b0101, 6'b000000, 6'd0,  32'h000F4240, 32'd0,       0, 33, 0);
        vecs[17] = mk(32'd100,      32'd7,        32'd0, 4'b0110, 6'b000000, 6'd0,  32'd14,       32'd2,       0, 33, 0);
        vecs[18] = mk(32'd100,      32'd0,        32'd0, 4'b0110, 6'b000000, 6'd0,  32'hFFFFFFFF, 32'd100,     0, 33, 0);
        vecs[19] = mk(32'hFFFFFFFF, 32'd10,       32'd0, 4'b0110, 6'b000000, 6'd0,  32'h19999999, 32'd5,       0, 33, 0);

        bus32.start = 1'b0; bus32.a = '0; bus32.b = '0; bus32.d = '0;
        bus32.alucontrol = '0; bus32.opcode = '0; bus32.shamt = '0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.d = '0;
        bus8.alucontrol = '0; bus8.opcode = '0; bus8.shamt = '0;
        reset = 1'b1;
        reset8 = 1'b1;
        repeat (3) @(negedge clk);

        chk("reset busy",   32'(bus32.busy), 32'd0);
        chk("reset done",   32'(bus32.done), 32'd0);
        chk("reset result", bus32.result,    32'd0);
        chk("reset hi",     bus32.hi,        32'd0);
        chk("reset zero",   32'(bus32.zero), 32'd0);
        chk("reset8 zero",  32'(bus8.zero),  32'd0);
        reset = 1'b0;
        reset8 = 1'b0;

        for (int i = 0; i < 20; i++) begin
            do_op(i);
        end

        // Result holds in IDLE.
        repeat (3) @(negedge clk);
        chk("held result", bus32.result, 32'h19999999);
        chk("held hi",     bus32.hi,     32'd5);

        // Back-to-back: start held high through a divide and into DONE.
        @(negedge clk);
        bus32.a = 32'd100; bus32.b = 32'd7; bus32.alucontrol = 4'b0110;
        bus32.opcode = 6'd0; bus32.start = 1'b1;
        cyc = 0; got = 0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus32.done) got = 1;
        end
        chk("b2b div latency", 32'(cyc), 32'd33);
        chk("b2b div result", bus32.result, 32'd14);
        bus32.a = 32'd1; bus32.b = 32'd1; bus32.alucontrol = 4'b0010;
        @(negedge clk);
        chk("b2b add done",   32'(bus32.done), 32'd1);
        chk("b2b add result", bus32.result,    32'd2);
        chk("b2b add hi",     bus32.hi,        32'd0);
        bus32.start = 1'b0;
        @(negedge clk);
        chk("b2b idle done", 32'(bus32.done), 32'd0);

        // Asynchronous reset ten cycles into a multiply.
        @(negedge clk);
        bus32.a = 32'hFFFFFFFF; bus32.b = 32'd3; bus32.alucontrol = 4'b0101;
        bus32.start = 1'b1;
        @(negedge clk);
        bus32.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre-reset busy", 32'(bus32.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async rst busy",   32'(bus32.busy), 32'd0);
        chk("async rst done",   32'(bus32.done), 32'd0);
        chk("async rst result", bus32.result,    32'd0);
        chk("async rst hi",     bus32.hi,        32'd0);
        chk("async rst zero",   32'(bus32.zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus32.done) extra++;
        end
        chk("aborted mul no done", 32'(extra), 32'd0);
        do_op(0);

        // Narrow datapath.
        op8("w8 mul", 8'hFF, 8'hFF, 4'b0101, 8'h01, 8'hFE, 9);
        op8("w8 div", 8'hFF, 8'h0A, 4'b0110, 8'h19, 8'h05, 9);
        op8("w8 dsh sentinel", 8'd40, 8'd3, 4'b1100, 8'hBE, 8'h00, 1);
        op8("w8 dsh width", 8'd11, 8'd3, 4'b1100, 8'h00, 8'h00, 1);
        op8("w8 add wrap", 8'hF0, 8'h20, 4'b0010, 8'h10, 8'h00, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Keeps the existing logic, add/sub, slt, srl and difference-shift operations, now with a registered result.
- Adds iterative unsigned multiply and divide with a hi/lo result pair.
- Sits in the execute stage; the controller stalls on busy and consumes result/hi/zero on done.

Parameters:
- WIDTH, 32: datapath width in bits (>=8).
- SENTINEL, 32'hc0debabe: difference-shift overflow value, truncated to WIDTH.
- CW, $clog2(WIDTH+1): width of the iteration counter and shift amount.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; accepted when state is IDLE or DONE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- d  in  WIDTH  difference-shift data operand.
- alucontrol  in  4  operation; bit 3 selects subtract/invert-b.
- opcode  in  6  branch type for zero evaluation.
- shamt  in  CW  srl shift amount.
- busy  out  1  high while a multi-cycle op iterates.
- done  out  1  one-cycle pulse when result/hi/zero are valid.
- result  out  WIDTH  low result (product low / quotient / op result).
- hi  out  WIDTH  product high / remainder; 0 for single-cycle ops.
- zero  out  1  branch condition of the registered result.

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, result=0, hi=0, zero=0.
- Reset mid-operation aborts the operation; there is no partial result.
- Operands, alucontrol and opcode are captured on the accepting edge. Later input changes are ignored until the next accept.
- FSM states IDLE, RUN, DONE:
  - IDLE + start: single-cycle op goes to DONE; mul/div goes to RUN with count=0.
  - RUN: count increments each cycle; after WIDTH iterations it goes to DONE.
  - DONE: done=1 for exactly one cycle. start here is accepted (back-to-back); otherwise go to IDLE.
- start during RUN is ignored; it is not queued.
- busy=1 only in RUN.
- Latency, counted from the accepting edge:
  - Single-cycle ops: done on the next cycle.
  - mul/div: done WIDTH+1 cycles later.
- Ops on alucontrol[2:0]:
  - 000: a&b.
  - 001: a|b.
  - 010: a + (bit3 ? ~b : b) + bit3, i.e. add or sub.
  - 011: slt = sign bit of that sum, zero-extended.
  - 100: difference shift. diff = a + ~b + bit3 (unsigned, WIDTH bits); if diff > WIDTH then SENTINEL, else d << diff. diff==WIDTH yields 0.
  - 101: unsigned multiply by shift-add, one bit per cycle; {hi,result} = a*b (2*WIDTH bits).
  - 110: unsigned restoring divide, one bit per cycle; result = a/b, hi = a%b. b==0 still takes full latency and gives result = all-ones, hi = a.
  - 111: result = b >> shamt. shamt >= WIDTH gives 0.
- result/hi/zero are held from done until the next accept; they are not cleared in IDLE.
- zero is computed from the final registered result, per captured opcode:
  - 100110 (bge): ~result[WIDTH-1].
  - 000001 (blt): result[WIDTH-1].
  - 000101 (bne): result != 0.
  - all other opcodes: result == 0.
- All arithmetic is modulo 2^WIDTH except the double-width product.
- No latches: every op code has a defined result.

Decomposition:
- Package alu_pkg holds:
  - enum alu_op_e for the 3-bit op codes;
  - opcode constants OP_BGE, OP_BLT, OP_BNE;
  - state enum alu_state_e (IDLE/RUN/DONE);
  - default SENTINEL.
- Sub-module iter_muldiv #(WIDTH) holds the mul/div iteration registers, driven by load/step/mode from the iter_alu FSM, which keeps the counter.
- Single-cycle ops stay in iter_alu.

Test Plan:
1. WIDTH=32. a=5, b=3, alucontrol=0010, opcode=0, start -> done one cycle later, result=8, hi=0, zero=0.
2. a=7, b=7, alucontrol=1010, opcode=000100 -> result=0, zero=1. Repeat with opcode=000101 -> zero=0. Then a=2, b=7, opcode=000001 -> result=FFFFFFFB, zero=1.
3. Multiply: a=FFFFFFFF, b=2, alucontrol=0101, start -> busy for 32 cycles, done at cycle 33, hi=1, result=FFFFFFFE. Extra start pulses during busy are ignored (no second done).
4. Divide: a=100, b=7, alucontrol=0110 -> result=14, hi=2. Then b=0 -> result=FFFFFFFF, hi=100, same latency. Then start held high in DONE -> back-to-back accept.
5. Difference shift: a=5, b=3, d=1, alucontrol=1100 -> result=4. a=40, b=3 -> result=C0DEBABE. a=35, b=3 (diff=32) -> result=0. Also srl: b=80000000, shamt=31, alucontrol=0111 -> result=1.
6. Reset asserted asynchronously 10 cycles into a multiply -> busy/done/result/hi/zero=0 immediately, no done pulse. A following add completes normally. Repeat with WIDTH=8: mul a=FF, b=FF -> hi=FE, result=01 after 9 cycles.
